// File: rtl/seg_sched_pkg.sv
// Shared types and helpers for the seven-segment display scheduler.
package seg_sched_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned WORD_W     = NUM_DIGITS * DIGIT_W;
    localparam int unsigned SCLK_W     = $clog2(NUM_DIGITS);
    localparam int unsigned MAX_SRC    = 8;
    localparam int unsigned IDX_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHOW   = 2'd1,
        ST_SWITCH = 2'd2
    } state_e;

    // First valid index after cur (wrapping); cur itself is tried last, so with
    // cur = n-1 this returns the lowest valid index. Returns cur if none valid.
    function automatic logic [IDX_W-1:0] rr_next(input logic [MAX_SRC-1:0] valid,
                                                 input logic [IDX_W-1:0]   cur,
                                                 input int unsigned        n);
        logic [IDX_W-1:0] res;
        logic             found;
        int unsigned      idx;
        res   = cur;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_SRC; k++) begin
            idx = (32'(cur) + k) % n;
            if (k <= n && !found && valid[idx[IDX_W-1:0]]) begin
                res   = idx[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // Bit k set when all nibbles from k upward are zero; digit 0 never blanks.
    function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(input logic [WORD_W-1:0] w);
        logic [NUM_DIGITS-1:0] m;
        m = '0;
        for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
            m[k] = ((w >> (k * DIGIT_W)) == '0);
        end
        return m;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Digit-scan prescaler: produces the scan tick, frame boundary and digit index.
module seg_scan_timer
    import seg_sched_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              tick_c_o,
    output logic              fb_c_o,
    output logic [SCLK_W-1:0] sclk_o
);

    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [SCLK_W-1:0] sclk_q, sclk_d;

    assign tick_c_o = (presc_q == PRE_W'(SCAN_DIV - 1));
    assign fb_c_o   = tick_c_o && (sclk_q == SCLK_W'(NUM_DIGITS - 1));
    assign sclk_o   = sclk_q;

    always_comb begin
        presc_d = presc_q + PRE_W'(1);
        sclk_d  = sclk_q;
        if (tick_c_o) begin
            presc_d = '0;
            sclk_d  = sclk_q + SCLK_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q <= '0;
            sclk_q  <= '0;
        end else begin
            presc_q <= presc_d;
            sclk_q  <= sclk_d;
        end
    end

endmodule

// File: rtl/seg_display_scheduler.sv
// Round-robin time-sharing of a 4-digit display among N_SRC sources, frame-aligned.
// Optional leading-zero blanking enabled by defining SEG_SCHED_BLANK_EN.
module seg_display_scheduler
    import seg_sched_pkg::*;
#(
    parameter int unsigned N_SRC        = 4,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DWELL_FRAMES = 1000,
    localparam int unsigned SEL_W       = $clog2(N_SRC)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_SRC-1:0]        src_valid_i,
    input  logic [WORD_W*N_SRC-1:0] src_data_i,
    output logic [N_SRC-1:0]        src_ack_o,
    input  logic                    freeze_i,
    output logic [SCLK_W-1:0]       sclk_o,
    output logic [WORD_W-1:0]       display_o,
    output logic [SEL_W-1:0]        src_sel_o,
    output logic [NUM_DIGITS-1:0]   blank_mask_o
);

    localparam int unsigned DWELL_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

    logic tick_c, fb_c, latch_c;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [WORD_W-1:0]   disp_q, disp_d;
    logic [N_SRC-1:0]    ack_q, ack_d;
    logic [MAX_SRC-1:0]  valid_c;
    logic [WORD_W-1:0]   words_c [N_SRC];

    seg_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .tick_c_o (tick_c),
        .fb_c_o   (fb_c),
        .sclk_o   (sclk_o)
    );

    assign valid_c = MAX_SRC'(src_valid_i);

    always_comb begin
        for (int unsigned i = 0; i < N_SRC; i++) begin
            words_c[i] = src_data_i[i*WORD_W +: WORD_W];
        end
    end

    // Scheduler FSM: grants, dwell counting and rotation all occur on frame boundaries.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        dwell_d = dwell_q;
        disp_d  = disp_q;
        ack_d   = '0;
        latch_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick_c && fb_c && (|src_valid_i)) begin
                    sel_d   = SEL_W'(rr_next(valid_c, IDX_W'(N_SRC - 1), N_SRC));
                    latch_c = 1'b1;
                    dwell_d = '0;
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (tick_c && fb_c) begin
                    latch_c = src_valid_i[sel_q];
                    if (dwell_q == DWELL_W'(DWELL_FRAMES - 1)) begin
                        if (!freeze_i) state_d = ST_SWITCH;
                    end else begin
                        dwell_d = dwell_q + DWELL_W'(1);
                    end
                end
            end
            ST_SWITCH: begin
                sel_d   = SEL_W'(rr_next(valid_c, IDX_W'(sel_q), N_SRC));
                dwell_d = '0;
                state_d = ST_SHOW;
            end
            default: state_d = ST_IDLE;
        endcase
        if (latch_c) begin
            disp_d       = words_c[sel_d];
            ack_d[sel_d] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            dwell_q <= '0;
            disp_q  <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dwell_q <= dwell_d;
            disp_q  <= disp_d;
            ack_q   <= ack_d;
        end
    end

    assign display_o = disp_q;
    assign src_sel_o = sel_q;
    assign src_ack_o = ack_q;

`ifdef SEG_SCHED_BLANK_EN
    logic [NUM_DIGITS-1:0] blank_q, blank_d;

    always_comb begin
        blank_d = blank_q;
        if (latch_c) blank_d = lead_zero_mask(words_c[sel_d]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) blank_q <= '0;
        else       blank_q <= blank_d;
    end

    assign blank_mask_o = blank_q;
`else
    assign blank_mask_o = '0;
`endif

endmodule
